seven_seg_scan_driver: RTL and testbench

- Parametrised, time-multiplexed seven-segment display driver for up to 16 hex digits.
- Generalises the fixed 4-digit display subsystem with:
  - configurable digit count and refresh rate;
  - per-digit enable and per-digit decimal point;
  - optional leading-zero blanking;
  - tear-free frame-synchronous capture of the displayed value.
- Sits between the processor debug outputs (ALU result / store data) and the board's segment cathodes and anodes.

---
 rtl/seven_seg_scan_driver_if.sv | 33 +++
 rtl/seven_seg_scan_driver.sv | 168 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// Bundle between the debug-value source and the scanned seven-segment driver.
// The source side (master) presents the value and display controls; the
// driver side (slave) returns the registered cathode/anode drives and the
// frame marker.
interface seven_seg_scan_driver_if #(
   parameter int NUM_DIGITS = 8
);
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic [NUM_DIGITS-1:0]   digit_enable;
   logic                    blank_lz;

   logic                    CA;
   logic                    CB;
   logic                    CC;
   logic                    CD;
   logic                    CE;
   logic                    CF;
   logic                    CG;
   logic                    DP;
   logic [NUM_DIGITS-1:0]   AN;
   logic                    frame_start;

   modport master (
      output value, dp_mask, digit_enable, blank_lz,
      input  CA, CB, CC, CD, CE, CF, CG, DP, AN, frame_start
   );

   modport slave (
      input  value, dp_mask, digit_enable, blank_lz,
      output CA, CB, CC, CD, CE, CF, CG, DP, AN, frame_start
   );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex display driver for up to 16 digits.
// A prescaler sets how long each digit stays lit, a digit index walks the
// anodes, and the displayed value is captured into shadow registers only at
// the frame boundary so a frame never mixes old and new digits.
// All outputs are registered from the next-state view of the scan, so the
// first cycle of digit 0 already shows the freshly captured shadow and lines
// up with frame_start.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                     clk,
   input  logic                     reset,
   seven_seg_scan_driver_if.slave   bus
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(REFRESH_DIV - 1);

   logic [DIV_W-1:0]        r_divCnt;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_shValue;
   logic [NUM_DIGITS-1:0]   r_shDp;
   logic [NUM_DIGITS-1:0]   r_shEn;
   logic                    r_shBlank;
   logic [NUM_DIGITS-1:0]   r_an;
   logic [6:0]              r_seg;
   logic                    r_dp;
   logic                    r_frameStart;

   logic                    w_tick;
   logic                    w_wrap;
   logic [DIV_W-1:0]        w_divNext;
   logic [IDX_W-1:0]        w_idxNext;
   logic [4*NUM_DIGITS-1:0] w_valueNext;
   logic [NUM_DIGITS-1:0]   w_dpNext;
   logic [NUM_DIGITS-1:0]   w_enNext;
   logic                    w_blankNext;
   logic [NUM_DIGITS-1:0]   w_blankMask;
   logic [3:0]              w_nibble;
   logic                    w_lit;
   logic [NUM_DIGITS-1:0]   w_anNext;
   logic [6:0]              w_segNext;
   logic                    w_dpOutNext;

   // Hex glyph table, bit 6 = segment a (CA) down to bit 0 = segment g (CG),
   // active-low; b and d are the lowercase forms so they differ from 8 and 0.
   function automatic logic [6:0] hexGlyph(input logic [3:0] nib);
      hexGlyph = 7'b1111111;
      case (nib)
         4'h0: hexGlyph = 7'b0000001;
         4'h1: hexGlyph = 7'b1001111;
         4'h2: hexGlyph = 7'b0010010;
         4'h3: hexGlyph = 7'b0000110;
         4'h4: hexGlyph = 7'b1001100;
         4'h5: hexGlyph = 7'b0100100;
         4'h6: hexGlyph = 7'b0100000;
         4'h7: hexGlyph = 7'b0001111;
         4'h8: hexGlyph = 7'b0000000;
         4'h9: hexGlyph = 7'b0000100;
         4'hA: hexGlyph = 7'b0001000;
         4'hB: hexGlyph = 7'b1100000;
         4'hC: hexGlyph = 7'b0110001;
         4'hD: hexGlyph = 7'b1000010;
         4'hE: hexGlyph = 7'b0110000;
         4'hF: hexGlyph = 7'b0111000;
         default: hexGlyph = 7'b1111111;
      endcase
   endfunction

   // Prescaler tick, frame wrap and the next scan position.
   always_comb begin
      w_tick    = (r_divCnt == LAST_DIV);
      w_wrap    = w_tick && (r_idx == LAST_IDX);
      w_divNext = w_tick ? '0 : r_divCnt + DIV_W'(1);
      w_idxNext = r_idx;
      if (w_wrap) begin
         w_idxNext = '0;
      end else if (w_tick) begin
         w_idxNext = r_idx + IDX_W'(1);
      end
   end

   // Shadow copy of the display controls, refreshed only on the frame wrap.
   always_comb begin
      w_valueNext = r_shValue;
      w_dpNext    = r_shDp;
      w_enNext    = r_shEn;
      w_blankNext = r_shBlank;
      if (w_wrap) begin
         w_valueNext = bus.value;
         w_dpNext    = bus.dp_mask;
         w_enNext    = bus.digit_enable;
         w_blankNext = bus.blank_lz;
      end
   end

   // Leading-zero mask: scan from the top digit down and blank every digit
   // above the highest non-zero nibble, always keeping digit 0 visible.
   always_comb begin
      logic w_seenNonZero;
      w_seenNonZero = 1'b0;
      w_blankMask   = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (w_valueNext[4*i +: 4] != 4'h0) begin
            w_seenNonZero = 1'b1;
         end
         if ((i != 0) && w_blankNext && !w_seenNonZero) begin
            w_blankMask[i] = 1'b1;
         end
      end
   end

   // Drive values for the digit that will be on screen after this edge.
   always_comb begin
      w_nibble    = w_valueNext[{w_idxNext, 2'b00} +: 4];
      w_lit       = w_enNext[w_idxNext] && !w_blankMask[w_idxNext];
      w_anNext    = '1;
      w_segNext   = 7'b1111111;
      w_dpOutNext = 1'b1;
      if (w_lit) begin
         w_anNext    = ~(NUM_DIGITS'(1) << w_idxNext);
         w_segNext   = hexGlyph(w_nibble);
         w_dpOutNext = ~w_dpNext[w_idxNext];
      end
   end

   // Scan state, shadow registers and registered display outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_divCnt     <= '0;
         r_idx        <= '0;
         r_shValue    <= '0;
         r_shDp       <= '0;
         r_shEn       <= '0;
         r_shBlank    <= 1'b0;
         r_an         <= '1;
         r_seg        <= 7'b1111111;
         r_dp         <= 1'b1;
         r_frameStart <= 1'b0;
      end else begin
         r_divCnt     <= w_divNext;
         r_idx        <= w_idxNext;
         r_shValue    <= w_valueNext;
         r_shDp       <= w_dpNext;
         r_shEn       <= w_enNext;
         r_shBlank    <= w_blankNext;
         r_an         <= w_anNext;
         r_seg        <= w_segNext;
         r_dp         <= w_dpOutNext;
         r_frameStart <= w_wrap;
      end
   end

   assign bus.CA          = r_seg[6];
   assign bus.CB          = r_seg[5];
   assign bus.CC          = r_seg[4];
   assign bus.CD          = r_seg[3];
   assign bus.CE          = r_seg[2];
   assign bus.CF          = r_seg[1];
   assign bus.CG          = r_seg[0];
   assign bus.DP          = r_dp;
   assign bus.AN          = r_an;
   assign bus.frame_start = r_frameStart;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for the scanned seven-segment driver (4 digits, 4 cycles per digit).
// A behavioural model tracks time since reset and the captured frame
// contents; every cycle its expected drive is compared with the DUT, and
// directed frames pin known glyph/anode patterns as literals.
module tb_seven_seg_scan_driver;

   localparam int N     = 4;
   localparam int R     = 4;
   localparam int FRAME = N * R;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

   seven_seg_scan_driver #(
      .NUM_DIGITS (N),
      .REFRESH_DIV(R)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit checkEn     = 1'b0;
   bit darkBeforeFs;

   logic [6:0] seg;
   assign seg = {bus.CA, bus.CB, bus.CC, bus.CD, bus.CE, bus.CF, bus.CG};

   // Model state: edges since reset release and the frame contents captured
   // at each frame boundary.
   int         mT;
   logic [15:0] mVal;
   logic [3:0]  mDp;
   logic [3:0]  mEn;
   logic        mBlank;

   // Lit segments of each hex digit, written as segment letters.
   string glyphTab[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                           "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                           "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   function automatic logic [6:0] glyphOf(input int d);
      string s;
      logic [6:0] bits;
      byte ch;
      s    = glyphTab[d];
      bits = 7'b1111111;
      for (int k = 0; k < s.len(); k++) begin
         ch = s[k];
         bits[6 - (ch - 8'h61)] = 1'b0;
      end
      return bits;
   endfunction

   // Expected {AN, CA..CG, DP, frame_start} after the most recent edge.
   function automatic logic [12:0] modelOutputs();
      int          idx;
      logic [15:0] upper;
      bit          blanked;
      bit          lit;
      logic [3:0]  an;
      logic [6:0]  sg;
      logic        dp;
      logic        fs;
      idx     = (mT / R) % N;
      upper   = mVal >> (4 * idx);
      blanked = (idx != 0) && mBlank && (upper == 16'h0);
      lit     = mEn[idx] && !blanked;
      an      = 4'hF;
      sg      = 7'b1111111;
      dp      = 1'b1;
      if (lit) begin
         an = ~(4'b0001 << idx);
         sg = glyphOf(int'(upper[3:0]));
         dp = ~mDp[idx];
      end
      fs = (mT > 0) && (mT % FRAME == 0);
      return {an, sg, dp, fs};
   endfunction

   // Advance the model on each edge; a frame is captured every FRAME edges.
   always @(posedge clk) begin
      if (reset) begin
         mT     <= 0;
         mVal   <= '0;
         mDp    <= '0;
         mEn    <= '0;
         mBlank <= 1'b0;
      end else begin
         mT <= mT + 1;
         if ((mT + 1) % FRAME == 0) begin
            mVal   <= bus.value;
            mDp    <= bus.dp_mask;
            mEn    <= bus.digit_enable;
            mBlank <= bus.blank_lz;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s @%0t: actual %0h, required %0h", name, $time, act, exp);
      end
   endtask

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model", {19'd0, bus.AN, seg, bus.DP, bus.frame_start}, {19'd0, modelOutputs()});
      end
   end

   task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dp,
                                input logic [3:0] en, input logic blz);
      bus.value        = v;
      bus.dp_mask      = dp;
      bus.digit_enable = en;
      bus.blank_lz     = blz;
   endtask

   task automatic stepCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitFrameStart(input int expCycles, input string name);
      int cycles;
      cycles       = 0;
      darkBeforeFs = 1'b1;
      while (cycles < 64) begin
         @(negedge clk);
         cycles++;
         if (bus.frame_start === 1'b1) break;
         if (bus.AN !== 4'hF) darkBeforeFs = 1'b0;
      end
      checkOutput(name, cycles, expCycles);
   endtask

   task automatic checkSlot(input string name, input logic [3:0] an,
                            input logic [6:0] sg, input logic dp);
      checkOutput({name, " AN"}, {28'd0, bus.AN}, {28'd0, an});
      checkOutput({name, " seg"}, {25'd0, seg}, {25'd0, sg});
      checkOutput({name, " DP"}, {31'd0, bus.DP}, {31'd0, dp});
   endtask

   // Check four consecutive digit slots starting at the current cycle; the
   // bench is left at the first cycle of the last slot.
   task automatic checkFrame(input string name, input logic [15:0] anP,
                             input logic [27:0] segP, input logic [3:0] dpP);
      for (int s = 0; s < N; s++) begin
         checkSlot($sformatf("%s slot%0d", name, s), anP[4*s +: 4], segP[7*s +: 7], dpP[s]);
         if (s < N - 1) stepCycles(R);
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired: actual timeout, required finish");
      $fatal(1, "[TB] simulation hung");
   end

   initial begin
      applyStimulus(16'h0000, 4'h0, 4'h0, 1'b0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkEn = 1'b1;
      checkSlot("reset", 4'hF, 7'b1111111, 1'b1);
      checkOutput("reset frame_start", {31'd0, bus.frame_start}, 32'd0);

      #1 reset = 1'b0;
      applyStimulus(16'h1234, 4'b0000, 4'b1111, 1'b0);
      waitFrameStart(16, "first frame_start");
      checkOutput("dark first frame", {31'd0, darkBeforeFs}, 32'd1);

      $display("[TB] frame with 0x1234");
      checkFrame("hex1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                 {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111);

      #1 applyStimulus(16'h0080, 4'b0000, 4'b1111, 1'b1);
      waitFrameStart(4, "frame period");
      checkFrame("lz0080", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                 {7'b1111111, 7'b1111111, 7'b0000000, 7'b0000001}, 4'b1111);

      #1 applyStimulus(16'h0000, 4'b0001, 4'b1111, 1'b1);
      waitFrameStart(4, "frame zero");
      checkFrame("lz0000", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                 {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1110);

      #1 applyStimulus(16'h1111, 4'b0000, 4'b1111, 1'b0);
      waitFrameStart(4, "frame 1111");
      stepCycles(R);
      #1 bus.value = 16'h2222;
      checkSlot("tear slot1", 4'b1101, 7'b1001111, 1'b1);
      stepCycles(R);
      checkSlot("tear slot2", 4'b1011, 7'b1001111, 1'b1);
      stepCycles(R);
      checkSlot("tear slot3", 4'b0111, 7'b1001111, 1'b1);
      waitFrameStart(4, "frame 2222");
      checkFrame("hex2222", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                 {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}, 4'b1111);

      waitFrameStart(4, "frame before reset");
      stepCycles(2 * R);
      #1 reset = 1'b1;
      @(negedge clk);
      checkSlot("mid reset", 4'hF, 7'b1111111, 1'b1);
      checkOutput("mid reset frame_start", {31'd0, bus.frame_start}, 32'd0);
      #1 reset = 1'b0;
      waitFrameStart(16, "frame_start after reset");
      checkOutput("dark after reset", {31'd0, darkBeforeFs}, 32'd1);
      checkSlot("after reset slot0", 4'b1110, 7'b0010010, 1'b1);

      $display("[TB] randomized phase");
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         #1;
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            reset = 1'b1;
         end
         if ($urandom_range(0, 99) < 10) begin
            logic [15:0] v;
            for (int k = 0; k < N; k++) begin
               v[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            applyStimulus(v, 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                          1'($urandom_range(0, 1)));
         end
      end
      reset = 1'b0;
      stepCycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
